ifq: RTL and testbench

//  Instruction fetch queue between ifu/inst_data_arbiter (upstream) and idu (downstream).

---
 rtl/ifq_pkg.sv | 17 +
 rtl/ifq_fifo.sv | 64 ++++++
 rtl/ifq.sv | 96 +++++++++
 tb/tb_ifq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Carries the {pc, instr} entry layout used by the queue storage and its top level.
package ifq_pkg;

    localparam int unsigned IFQ_DEPTH    = 4;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetch entries with an explicit count for full/empty.
// Flush clears pointers and count in one cycle; storage contents are left stale.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned EW = $bits(fetch_entry_t)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [EW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [EW-1:0] head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push_i & (count_q != CW'(DEPTH));
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= fetch_entry_t'(wdata_i);
    end

    assign head_o  = EW'(mem_q[rd_ptr_q]);
    assign count_o = count_q;

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: owns the fetch PC, issues word reads, buffers {pc, instr} for decode.
// Optional IFQ_BYPASS_EN: a response arriving at an empty queue is presented to decode directly.
module ifq
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    input  logic                         mem_gnt,
    output logic                         fetch_req,
    output logic [9:0]                   fetch_addr,
    input  logic [31:0]                  fetch_rdata,
    output logic                         out_valid,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_instr,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count;
    logic [CW:0]   pending;
    logic          issued, bypass, push, pop;
    logic [EW-1:0] head_bits;
    fetch_entry_t  head;

    // Reserve a slot for the in-flight word so a response can always be stored.
    assign pending   = {1'b0, count} + (CW+1)'(inflight_q);
    assign fetch_req = i_rst & ~redirect_valid & (pending < (CW+1)'(DEPTH));
    assign issued    = fetch_req & mem_gnt;
    assign fetch_addr = fetch_pc_q[11:2];

`ifdef IFQ_BYPASS_EN
    assign bypass = inflight_q & (count == '0) & ~redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign head      = fetch_entry_t'(head_bits);
    assign out_valid = (count != '0) | bypass;
    assign out_pc    = bypass ? inflight_pc_q : head.pc;
    assign out_instr = bypass ? fetch_rdata   : head.instr;
    assign occupancy = count;

    // A bypassed word consumed by decode never enters storage.
    assign pop  = out_valid & out_ready & ~bypass;
    assign push = inflight_q & ~redirect_valid & ~(bypass & out_ready);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
        end else if (issued) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i ({inflight_pc_q, fetch_rdata}),
        .pop_i   (pop),
        .head_o  (head_bits),
        .count_o (count)
    );

endmodule

// File: tb/tb_ifq.sv
// Directed bench for ifq with a registered 1024-word memory model; word i holds {i, 22'h13}.
// Expected first-output latency follows IFQ_BYPASS_EN (1 cycle) or its absence (2 cycles).
module tb_ifq;

`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        i_rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_gnt;
    logic        fetch_req;
    logic [9:0]  fetch_addr;
    logic [31:0] fetch_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  occupancy;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_pc;
    logic [9:0]  exp_addr;
    logic [31:0] mem [1024];

    ifq #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_gnt        (mem_gnt),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_rdata    (fetch_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] idx;
            idx = 10'(i);
            mem[i] = {idx, 22'h000013};
        end
    end

    always @(posedge clk) begin
        if (fetch_req && mem_gnt) fetch_rdata <= mem[fetch_addr];
        else                      fetch_rdata <= 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[11:2], 22'h000013};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        next_cycle();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_gnt = 1'b1; out_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", fetch_req); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
        n_checks++; if (fetch_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", fetch_addr); end
        next_cycle();
    endtask

    task automatic test_stream();
        logic [2:0] exp_occ;
        i_rst = 1'b1; mem_gnt = 1'b1; out_ready = 1'b1; exp_pc = 32'h0;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_occ = (LAT == 2 && c >= 2) ? 3'd1 : 3'd0;
            n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL stream_req c%0d: got %b expected 1", c, fetch_req); end
            n_checks++; if (fetch_addr !== 10'(c)) begin n_fail++; $display("FAIL stream_addr c%0d: got %0d expected %0d", c, fetch_addr, c); end
            n_checks++; if (out_valid !== logic'(c >= LAT)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b expected %b", c, out_valid, c >= LAT); end
            n_checks++; if (occupancy !== exp_occ) begin n_fail++; $display("FAIL stream_occ c%0d: got %0d expected %0d", c, occupancy, exp_occ); end
            if (out_valid && out_ready) begin
                n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc: got %h expected %h", out_pc, exp_pc); end
                n_checks++; if (out_instr !== word_of(exp_pc)) begin n_fail++; $display("FAIL stream_instr: got %h expected %h", out_instr, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            next_cycle();
        end
        n_checks++; if (exp_pc !== 32'(4 * (12 - LAT))) begin n_fail++; $display("FAIL stream_count: got %h expected %h", exp_pc, 32'(4 * (12 - LAT))); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++; if (occupancy > 3'd4) begin n_fail++; $display("FAIL bp_occ_bound c%0d: got %0d expected <=4", c, occupancy); end
            if (c == 9) begin
                n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occ_full: got %0d expected 4", occupancy); end
                n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full: got %b expected 0", fetch_req); end
            end
            next_cycle();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid c%0d: got %b expected 1", c, out_valid); end
            if (out_valid && out_ready) begin
                n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL bp_pc: got %h expected %h", out_pc, exp_pc); end
                n_checks++; if (out_instr !== word_of(exp_pc)) begin n_fail++; $display("FAIL bp_instr: got %h expected %h", out_instr, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            next_cycle();
        end
    endtask

    task automatic test_gnt_toggle();
        logic [3:0] pat;
        pat = 4'b1001;
        out_ready = 1'b1; mem_gnt = 1'b1;
        do_redirect(32'h0000_0100);
        exp_pc = 32'h100; exp_addr = 10'd64;
        for (int c = 0; c < 16; c++) begin
            mem_gnt = pat[c % 4];
            #1;
            n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL gnt_req c%0d: got %b expected 1", c, fetch_req); end
            n_checks++; if (fetch_addr !== exp_addr) begin n_fail++; $display("FAIL gnt_addr c%0d: got %0d expected %0d", c, fetch_addr, exp_addr); end
            if (out_valid && out_ready) begin
                n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL gnt_pc: got %h expected %h", out_pc, exp_pc); end
                n_checks++; if (out_instr !== word_of(exp_pc)) begin n_fail++; $display("FAIL gnt_instr: got %h expected %h", out_instr, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            if (mem_gnt) exp_addr = exp_addr + 10'd1;
            next_cycle();
        end
        mem_gnt = 1'b1;
        n_checks++; if (exp_pc !== 32'h11C) begin n_fail++; $display("FAIL gnt_count: got %h expected %h", exp_pc, 32'h11C); end
    endtask

    task automatic test_redirect_flush();
        out_ready = 1'b0; mem_gnt = 1'b1;
        do_redirect(32'h0000_0100);
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (k == 4) begin
                n_checks++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL flush_pre_occ2: got %0d expected 2", occupancy); end
                n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL flush_pre_req: got %b expected 1", fetch_req); end
            end
            next_cycle();
        end
        #1;
        n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ3: got %0d expected 3", occupancy); end
        n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL flush_pre_full: got %b expected 0", fetch_req); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        next_cycle();
        redirect_valid = 1'b0;
        out_ready = 1'b1; exp_pc = 32'h40;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0) begin
                n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
                n_checks++; if (fetch_addr !== 10'd16) begin n_fail++; $display("FAIL flush_addr: got %0d expected 16", fetch_addr); end
            end
            n_checks++; if (out_valid !== logic'(c >= LAT)) begin n_fail++; $display("FAIL flush_valid c%0d: got %b expected %b", c, out_valid, c >= LAT); end
            if (out_valid && out_ready) begin
                n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL flush_pc: got %h expected %h", out_pc, exp_pc); end
                n_checks++; if (out_instr !== word_of(exp_pc)) begin n_fail++; $display("FAIL flush_instr: got %h expected %h", out_instr, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect_pop_resp();
        out_ready = 1'b0; mem_gnt = 1'b1;
        do_redirect(32'h0000_0200);
        next_cycle();
        next_cycle();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rpr_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_pc !== 32'h200) begin n_fail++; $display("FAIL rpr_pop_pc: got %h expected %h", out_pc, 32'h200); end
        n_checks++; if (out_instr !== word_of(32'h200)) begin n_fail++; $display("FAIL rpr_pop_instr: got %h expected %h", out_instr, word_of(32'h200)); end
        next_cycle();
        redirect_valid = 1'b0;
        exp_pc = 32'h80;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 0) begin
                n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rpr_occ: got %0d expected 0", occupancy); end
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rpr_empty: got %b expected 0", out_valid); end
            end
            if (out_valid && out_ready) begin
                n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL rpr_pc: got %h expected %h", out_pc, exp_pc); end
                n_checks++; if (out_instr !== word_of(exp_pc)) begin n_fail++; $display("FAIL rpr_instr: got %h expected %h", out_instr, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            next_cycle();
        end
        n_checks++; if (exp_pc !== 32'(32'h80 + 4 * (6 - LAT))) begin n_fail++; $display("FAIL rpr_count: got %h expected %h", exp_pc, 32'(32'h80 + 4 * (6 - LAT))); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1; mem_gnt = 1'b1;
        do_redirect(32'hFFFF_FFFB);
        exp_pc = 32'hFFFF_FFF8; exp_addr = 10'd1022;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_checks++; if (fetch_addr !== exp_addr) begin n_fail++; $display("FAIL wrap_addr c%0d: got %0d expected %0d", c, fetch_addr, exp_addr); end
            if (out_valid && out_ready) begin
                n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", out_pc, exp_pc); end
                n_checks++; if (out_instr !== word_of(exp_pc)) begin n_fail++; $display("FAIL wrap_instr: got %h expected %h", out_instr, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            exp_addr = exp_addr + 10'd1;
            next_cycle();
        end
        n_checks++; if (exp_pc !== 32'(32'hFFFF_FFF8 + 4 * (8 - LAT))) begin n_fail++; $display("FAIL wrap_count: got %h expected %h", exp_pc, 32'(32'hFFFF_FFF8 + 4 * (8 - LAT))); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; mem_gnt = 1'b1;
        do_redirect(32'h0000_0300);
        for (int c = 0; c < 8; c++) next_cycle();
        #1;
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL rmid_full: got %0d expected 4", occupancy); end
        i_rst = 1'b0;
        next_cycle();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rmid_occ: got %0d expected 0", occupancy); end
        n_checks++; if (fetch_addr !== 10'd0) begin n_fail++; $display("FAIL rmid_addr: got %0d expected 0", fetch_addr); end
        n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %b expected 0", fetch_req); end
        next_cycle();
        i_rst = 1'b1; out_ready = 1'b1; exp_pc = 32'h0;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_checks++; if (out_valid !== logic'(c >= LAT)) begin n_fail++; $display("FAIL rmid_restart_valid c%0d: got %b expected %b", c, out_valid, c >= LAT); end
            if (out_valid && out_ready) begin
                n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL rmid_pc: got %h expected %h", out_pc, exp_pc); end
                n_checks++; if (out_instr !== word_of(exp_pc)) begin n_fail++; $display("FAIL rmid_instr: got %h expected %h", out_instr, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            next_cycle();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_toggle();
        test_redirect_flush();
        test_redirect_pop_resp();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
